// File: rtl/instr_fetch_if.sv
// Instruction memory bus between the fetch unit (master) and instruction memory (slave).
// Latency: none of its own, signals only.
// Handshake: I_req is held with a stable I_addr until the slave returns a one-cycle I_ack with I_data.
interface instr_fetch_if #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
);
    logic [ADDR_W-1:0]  I_addr;
    logic               I_req;
    logic               I_ack;
    logic [INSTR_W-1:0] I_data;

    modport master (
        output I_addr,
        output I_req,
        input  I_ack,
        input  I_data
    );

    modport slave (
        input  I_addr,
        input  I_req,
        output I_ack,
        output I_data
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch front end: program counter, instruction memory requests,
// a one-entry prefetch buffer and the instruction register seen by the control unit.
// Latency: consume to next Pf_valid is 1 cycle plus memory wait cycles; reset release to
// first Pf_valid is 2 cycles with a zero-wait memory.
// Backpressure: an Id&PC_up arriving while the buffer is empty raises Stall until the
// outstanding fetch returns and IR is loaded directly from memory.
//
// Ports:
//   Clk, Reset          rising-edge clock, asynchronous active-high reset
//   PC_clr, PC_up, Id   control-unit strobes (clear / advance PC / load IR)
//   mem                 instruction memory bus (master side): I_addr, I_req, I_ack, I_data
//   IRdata              instruction register
//   PC                  address of the next instruction to be consumed
//   Pf_valid            prefetch buffer holds mem[PC]
//   Stall               Id accepted but IR not yet updated
//   Halted              only when FETCH_HALT_DETECT_EN is defined: a HALT (opcode 4'h5)
//                       was loaded into IR; only PC_clr or Reset leaves this state
module instr_fetch #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               PC_clr,
    input  logic               PC_up,
    input  logic               Id,
    instr_fetch_if.master      mem,
    output logic [INSTR_W-1:0] IRdata,
    output logic [ADDR_W-1:0]  PC,
    output logic               Pf_valid,
    output logic               Stall
`ifdef FETCH_HALT_DETECT_EN
    ,
    output logic               Halted
`endif
);

`ifdef FETCH_HALT_DETECT_EN
    typedef enum logic [1:0] {S_CLR, S_REQ, S_FULL, S_HALT} state_t;
`else
    typedef enum logic [1:0] {S_CLR, S_REQ, S_FULL} state_t;
`endif

    state_t             state;
    logic [INSTR_W-1:0] pf_dat;   // prefetch buffer; valid exactly when Pf_valid=1
    logic               pending;  // Id&PC_up accepted while the buffer was empty
    logic               req;      // registered I_req
    logic               accept;   // Id&PC_up arriving this cycle with an empty buffer

`ifdef FETCH_HALT_DETECT_EN
    function automatic logic is_halt(input logic [INSTR_W-1:0] word);
        return word[INSTR_W-1 -: 4] == 4'h5;
    endfunction
`endif

    // A consume request that cannot be served from the buffer. Once pending is set,
    // further strobes are ignored until the IR load.
    always_comb begin
        accept = 1'b0;
        if (!PC_clr && !pending && Id && PC_up && (state == S_REQ || state == S_CLR)) begin
            accept = 1'b1;
        end
    end

    assign Stall      = pending | accept;
    assign mem.I_req  = req;
    assign mem.I_addr = req ? PC : '0;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= S_CLR;
            PC       <= '0;
            IRdata   <= '0;
            pf_dat   <= '0;
            Pf_valid <= 1'b0;
            pending  <= 1'b0;
            req      <= 1'b0;
`ifdef FETCH_HALT_DETECT_EN
            Halted   <= 1'b0;
`endif
        end else if (PC_clr) begin
            // Highest priority: any ack arriving in this cycle is dropped.
            state    <= S_CLR;
            PC       <= '0;
            IRdata   <= '0;
            Pf_valid <= 1'b0;
            pending  <= 1'b0;
            req      <= 1'b0;
`ifdef FETCH_HALT_DETECT_EN
            Halted   <= 1'b0;
`endif
        end else begin
            case (state)
                S_CLR: begin
                    // One idle cycle with I_req low, then start fetching mem[PC].
                    state <= S_REQ;
                    req   <= 1'b1;
                    if (accept) begin
                        pending <= 1'b1;
                    end
                end

                S_REQ: begin
                    if (mem.I_ack) begin
                        if (pending || accept) begin
                            // A consumer is waiting: bypass the buffer and keep
                            // requesting, now for the advanced PC.
                            IRdata  <= mem.I_data;
                            PC      <= PC + 1'b1;
                            pending <= 1'b0;
`ifdef FETCH_HALT_DETECT_EN
                            if (is_halt(mem.I_data)) begin
                                state  <= S_HALT;
                                req    <= 1'b0;
                                Halted <= 1'b1;
                            end
`endif
                        end else begin
                            pf_dat   <= mem.I_data;
                            Pf_valid <= 1'b1;
                            req      <= 1'b0;
                            state    <= S_FULL;
                        end
                    end else if (accept) begin
                        pending <= 1'b1;
                    end
                end

                S_FULL: begin
                    if (Id) begin
                        IRdata <= pf_dat;
                    end
                    if (PC_up) begin
                        PC       <= PC + 1'b1;
                        Pf_valid <= 1'b0;
                        req      <= 1'b1;
                        state    <= S_REQ;
                    end
`ifdef FETCH_HALT_DETECT_EN
                    // Overrides the refetch above: a loaded HALT freezes fetching.
                    if (Id && is_halt(pf_dat)) begin
                        Pf_valid <= 1'b0;
                        req      <= 1'b0;
                        Halted   <= 1'b1;
                        state    <= S_HALT;
                    end
`endif
                end

`ifdef FETCH_HALT_DETECT_EN
                S_HALT: begin
                    // Frozen until PC_clr or Reset.
                    req <= 1'b0;
                end
`endif

                default: begin
                    state <= S_CLR;
                    req   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch with a behavioural instruction memory
// whose ack delay is programmable per phase; expected values are hand-computed.
// Covers reset, prefetch, consume, stalled consume, wrap, PC_clr vs ack, reset mid-request, HALT.
module tb_instr_fetch;
    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 16;

    logic Clk = 1'b0;
    logic Reset;
    logic PC_clr, PC_up, Id;
    logic [INSTR_W-1:0] IRdata;
    logic [ADDR_W-1:0]  PC;
    logic Pf_valid, Stall;
`ifdef FETCH_HALT_DETECT_EN
    logic Halted;
`endif

    instr_fetch_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();

    instr_fetch #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .PC_clr   (PC_clr),
        .PC_up    (PC_up),
        .Id       (Id),
        .mem      (bus),
        .IRdata   (IRdata),
        .PC       (PC),
        .Pf_valid (Pf_valid),
        .Stall    (Stall)
`ifdef FETCH_HALT_DETECT_EN
        ,
        .Halted   (Halted)
`endif
    );

    always #5 Clk = ~Clk;

    // Memory model: ack in the (wait_cfg+1)-th cycle of a request, unless held off.
    logic [INSTR_W-1:0] mem [0:255];
    int   wait_cfg;
    logic ack_hold;
    logic force_ack;
    int   wcnt;

    assign bus.I_ack  = bus.I_req && (force_ack || (!ack_hold && wcnt == wait_cfg));
    assign bus.I_data = mem[bus.I_addr];

    always @(posedge Clk) begin
        if (!bus.I_req || bus.I_ack) wcnt <= 0;
        else                         wcnt <= wcnt + 1;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #2;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h1000 | 16'(i);
        mem[0]   = 16'h21A2;
        mem[1]   = 16'h3B47;
        mem[255] = 16'h9ABC;
        wait_cfg  = 0;
        ack_hold  = 1'b0;
        force_ack = 1'b0;
        wcnt      = 0;
        Reset = 1'b1; PC_clr = 1'b0; PC_up = 1'b0; Id = 1'b0;

        // Reset state
        step(); step();
        check("rst_pc", 32'(PC), 0);
        check("rst_ir", 32'(IRdata), 0);
        check("rst_pf", 32'(Pf_valid), 0);
        check("rst_req", 32'(bus.I_req), 0);
        check("rst_stall", 32'(Stall), 0);
        check("rst_addr", 32'(bus.I_addr), 0);

        // Release: cycle 0 in S_CLR, cycle 1 request, cycle 2 buffer full
        Reset = 1'b0;
        #1 check("clr_req", 32'(bus.I_req), 0);
        step();
        check("c1_req", 32'(bus.I_req), 1);
        check("c1_addr", 32'(bus.I_addr), 0);
        check("c1_pf", 32'(Pf_valid), 0);
        step();
        check("c2_pf", 32'(Pf_valid), 1);
        check("c2_req", 32'(bus.I_req), 0);
        check("c2_ir", 32'(IRdata), 0);

        // Normal consume; next fetch acks in its 3rd cycle
        wait_cfg = 2;
        Id = 1'b1; PC_up = 1'b1;
        #1 check("full_stall", 32'(Stall), 0);
        step();
        Id = 1'b0; PC_up = 1'b0;
        check("cons_ir", 32'(IRdata), 32'h21A2);
        check("cons_pc", 32'(PC), 1);
        check("cons_req", 32'(bus.I_req), 1);
        check("cons_addr", 32'(bus.I_addr), 1);

        // Consume during the request: stall for the 3 request cycles
        Id = 1'b1; PC_up = 1'b1;
        #1 check("stall_a", 32'(Stall), 1);
        step();
        Id = 1'b0; PC_up = 1'b0;
        #1 check("stall_b", 32'(Stall), 1);
        check("stall_b_ir", 32'(IRdata), 32'h21A2);
        step();
        check("stall_c", 32'(Stall), 1);
        check("stall_c_ack", 32'(bus.I_ack), 1);
        step();
        wait_cfg = 0;
        #1 check("pend_ir", 32'(IRdata), 32'h3B47);
        check("pend_pc", 32'(PC), 2);
        check("pend_stall", 32'(Stall), 0);
        check("pend_addr", 32'(bus.I_addr), 2);
        step();
        check("pend_pf", 32'(Pf_valid), 1);

        // Advance to PC=FF, then consume across the wrap
        for (int i = 0; i < 253; i++) begin
            PC_up = 1'b1; step();
            PC_up = 1'b0; step();
        end
        check("pre_wrap_pc", 32'(PC), 32'hFF);
        Id = 1'b1; PC_up = 1'b1;
        step();
        Id = 1'b0; PC_up = 1'b0;
        check("wrap_pc", 32'(PC), 0);
        check("wrap_addr", 32'(bus.I_addr), 0);
        check("wrap_ir", 32'(IRdata), 32'h9ABC);
        step();

        // Id alone from a full buffer: IR loads, PC holds
        Id = 1'b1; step(); Id = 1'b0;
        check("id_only_ir", 32'(IRdata), 32'h21A2);
        check("id_only_pc", 32'(PC), 0);
        check("id_only_pf", 32'(Pf_valid), 1);

        // Reach PC=5 with an outstanding, unacked request
        for (int i = 0; i < 4; i++) begin
            PC_up = 1'b1; step();
            PC_up = 1'b0; step();
        end
        ack_hold = 1'b1;
        PC_up = 1'b1; step(); PC_up = 1'b0;
        check("out_addr", 32'(bus.I_addr), 5);
        Id = 1'b1;
        #1 check("id_empty_stall", 32'(Stall), 0);
        step();
        Id = 1'b0;
        check("id_empty_ir", 32'(IRdata), 32'h21A2);
        check("id_empty_pc", 32'(PC), 5);
        step();

        // PC_clr in the same cycle as the ack: ack dropped
        force_ack = 1'b1; PC_clr = 1'b1;
        #1 check("clr_ack_seen", 32'(bus.I_ack), 1);
        step();
        force_ack = 1'b0; PC_clr = 1'b0;
        check("clr_pc", 32'(PC), 0);
        check("clr_ir", 32'(IRdata), 0);
        check("clr_req_lo", 32'(bus.I_req), 0);
        check("clr_pf", 32'(Pf_valid), 0);
        step();
        check("clr_req_hi", 32'(bus.I_req), 1);
        check("clr_addr", 32'(bus.I_addr), 0);

        // Reset mid-request drops I_req asynchronously
        #1 Reset = 1'b1;
        #1 check("arst_req", 32'(bus.I_req), 0);
        step();
        Reset = 1'b0;
        #1 check("arst_clr_req", 32'(bus.I_req), 0);
        step();
        check("arst_req_hi", 32'(bus.I_req), 1);

        // HALT word
        mem[0] = 16'h5000;
        ack_hold = 1'b0;
        step();
        check("halt_pf", 32'(Pf_valid), 1);
        Id = 1'b1; PC_up = 1'b1;
        step();
        Id = 1'b0; PC_up = 1'b0;
        check("halt_ir", 32'(IRdata), 32'h5000);
        check("halt_pc", 32'(PC), 1);
`ifdef FETCH_HALT_DETECT_EN
        check("halted", 32'(Halted), 1);
        check("halt_req", 32'(bus.I_req), 0);
        Id = 1'b1; PC_up = 1'b1;
        #1 check("halt_stall", 32'(Stall), 0);
        step();
        Id = 1'b0; PC_up = 1'b0;
        check("halt_frz_pc", 32'(PC), 1);
        check("halt_frz_ir", 32'(IRdata), 32'h5000);
        check("halt_frz_req", 32'(bus.I_req), 0);
        PC_clr = 1'b1; step(); PC_clr = 1'b0;
        check("halt_clr", 32'(Halted), 0);
        check("halt_clr_pc", 32'(PC), 0);
`else
        check("nohalt_req", 32'(bus.I_req), 1);
        check("nohalt_addr", 32'(bus.I_addr), 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
